// File: rtl/branch_resolve_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_pkg
//   Shared definitions for the ID-stage branch resolver:
//   - MIPS opcode and REGIMM rt-field encodings for the branches handled
//   - FSM state type (RUN / STALL)
//   - branch-kind type and a decode helper used by the top level
// ---------------------------------------------------------------------------
package branch_resolve_unit_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  // REGIMM sub-opcodes (instr[20:16])
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } brs_state_t;

  // Compare kind; the linking REGIMM forms reuse BLTZ/BGEZ plus a link flag.
  typedef enum logic [2:0] {
    BK_NONE = 3'd0,
    BK_BEQ  = 3'd1,
    BK_BNE  = 3'd2,
    BK_BLEZ = 3'd3,
    BK_BGTZ = 3'd4,
    BK_BLTZ = 3'd5,
    BK_BGEZ = 3'd6
  } brs_kind_t;

  typedef struct packed {
    brs_kind_t kind;
    logic      use_rt;  // rt is a real source operand (beq/bne only)
    logic      link;    // writes r31
  } brs_dec_t;

  function automatic brs_dec_t brs_decode(input logic [5:0] op,
                                          input logic [4:0] rt,
                                          input logic       link_en);
    brs_dec_t d;
    d.kind   = BK_NONE;
    d.use_rt = 1'b0;
    d.link   = 1'b0;
    case (op)
      OP_BEQ:  begin d.kind = BK_BEQ; d.use_rt = 1'b1; end
      OP_BNE:  begin d.kind = BK_BNE; d.use_rt = 1'b1; end
      OP_BLEZ: if (rt == 5'd0) d.kind = BK_BLEZ;
      OP_BGTZ: if (rt == 5'd0) d.kind = BK_BGTZ;
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ: d.kind = BK_BLTZ;
          RT_BGEZ: d.kind = BK_BGEZ;
          RT_BLTZAL: if (link_en) begin d.kind = BK_BLTZ; d.link = 1'b1; end
          RT_BGEZAL: if (link_en) begin d.kind = BK_BGEZ; d.link = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_operand_forward_mux.sv
// ---------------------------------------------------------------------------
// operand_forward_mux
//   Picks the freshest value of one source register for the ID-stage compare.
//   Priority: EX > MEM > WB > register file. r0 is never forwarded.
//   Ports:
//     i_idx        source register index
//     i_rf         register-file read value
//     i_ex_*       EX stage write-back info and ALU/hilo result
//     i_mem_*      MEM stage write-back info, ALU output and load data
//     i_wb_*       WB stage write-back info and result
//     o_data       selected operand
// ---------------------------------------------------------------------------
module operand_forward_mux #(
  parameter int DATA_W = 32
) (
  input  logic [4:0]        i_idx,
  input  logic [DATA_W-1:0] i_rf,
  input  logic              i_ex_rw,
  input  logic [4:0]        i_ex_wr,
  input  logic [DATA_W-1:0] i_ex_data,
  input  logic              i_mem_rw,
  input  logic              i_mem_mr,
  input  logic [4:0]        i_mem_wr,
  input  logic [DATA_W-1:0] i_mem_alu,
  input  logic [DATA_W-1:0] i_mem_dm,
  input  logic              i_wb_rw,
  input  logic [4:0]        i_wb_wr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_data
);

  logic w_nz, w_ex_hit, w_mem_hit, w_wb_hit;

  assign w_nz      = (i_idx != 5'd0);
  assign w_ex_hit  = w_nz && i_ex_rw  && (i_ex_wr  == i_idx);
  assign w_mem_hit = w_nz && i_mem_rw && (i_mem_wr == i_idx);
  assign w_wb_hit  = w_nz && i_wb_rw  && (i_wb_wr  == i_idx);

  always_comb begin
    o_data = i_rf;
    if (w_ex_hit)       o_data = i_ex_data;
    else if (w_mem_hit) o_data = i_mem_mr ? i_mem_dm : i_mem_alu;
    else if (w_wb_hit)  o_data = i_wb_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//   Resolves conditional branches in ID. Operands come through forwarding
//   muxes; a load still in EX that feeds a used operand stalls IF/ID for one
//   evaluation, after which the load data is forwarded from MEM.
//   All state updates on the FALLING edge of Clk so the pipeline can consume
//   the results on the next rising edge.
//   Ports:
//     Clk, Rst_n                  clock, async active-low reset
//     ID_Instr, ID_Valid          instruction in ID and its valid bit
//     ID_ReadData1/2              register-file rs/rt values
//     EX_* / MEM_* / WB_*         downstream write-back info for forwarding
//     Branch, JumpAmount          taken flag and offset (0 when not taken)
//     Link                        linking branch resolved (write r31)
//     Stall                       hold IF/ID this cycle
//     BranchCount, TakenCount     saturating resolution statistics
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int OFF_W   = 16,
  parameter int CNT_W   = 16,
  parameter int LINK_EN = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [31:0]       ID_Instr,
  input  logic              ID_Valid,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic              EX_RegWrite,
  input  logic              EX_MemRead,
  input  logic [4:0]        EX_WriteReg,
  input  logic [DATA_W-1:0] EX_Result,
  input  logic              MEM_RegWrite,
  input  logic              MEM_MemRead,
  input  logic [4:0]        MEM_WriteReg,
  input  logic [DATA_W-1:0] MEM_AluOut,
  input  logic [DATA_W-1:0] MEM_DataMemOut,
  input  logic              WB_RegWrite,
  input  logic [4:0]        WB_WriteReg,
  input  logic [DATA_W-1:0] WB_Result,
  output logic              Branch,
  output logic [OFF_W-1:0]  JumpAmount,
  output logic              Link,
  output logic              Stall,
  output logic [CNT_W-1:0]  BranchCount,
  output logic [CNT_W-1:0]  TakenCount
);

  // ---------------- decode ----------------
  logic [4:0]       w_rs, w_rt;
  brs_dec_t         w_dec;
  logic             w_is_br;
  logic [OFF_W-1:0] w_off;

  assign w_rs    = ID_Instr[25:21];
  assign w_rt    = ID_Instr[20:16];
  assign w_dec   = brs_decode(ID_Instr[31:26], w_rt, (LINK_EN != 0));
  assign w_is_br = ID_Valid && (w_dec.kind != BK_NONE);

  generate
    if (OFF_W > 16) begin : g_off_sx
      assign w_off = {{(OFF_W-16){ID_Instr[15]}}, ID_Instr[15:0]};
    end else begin : g_off_tr
      assign w_off = ID_Instr[OFF_W-1:0];
    end
  endgenerate

  // ---------------- operand forwarding (rs = 0, rt = 1) ----------------
  logic [1:0][4:0]        w_idx;
  logic [1:0][DATA_W-1:0] w_rf;
  logic [1:0][DATA_W-1:0] w_opnd;

  assign w_idx = {w_rt, w_rs};
  assign w_rf  = {ID_ReadData2, ID_ReadData1};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    operand_forward_mux #(.DATA_W(DATA_W)) u_fwd (
      .i_idx     (w_idx[g]),
      .i_rf      (w_rf[g]),
      .i_ex_rw   (EX_RegWrite),
      .i_ex_wr   (EX_WriteReg),
      .i_ex_data (EX_Result),
      .i_mem_rw  (MEM_RegWrite),
      .i_mem_mr  (MEM_MemRead),
      .i_mem_wr  (MEM_WriteReg),
      .i_mem_alu (MEM_AluOut),
      .i_mem_dm  (MEM_DataMemOut),
      .i_wb_rw   (WB_RegWrite),
      .i_wb_wr   (WB_WriteReg),
      .i_wb_data (WB_Result),
      .o_data    (w_opnd[g])
    );
  end

  // ---------------- condition ----------------
  logic signed [DATA_W-1:0] w_a, w_b;
  logic                     w_cond;

  assign w_a = w_opnd[0];
  assign w_b = w_opnd[1];

  always_comb begin
    w_cond = 1'b0;
    case (w_dec.kind)
      BK_BEQ:  w_cond = (w_a == w_b);
      BK_BNE:  w_cond = (w_a != w_b);
      BK_BLEZ: w_cond = (w_a <= 0);
      BK_BGTZ: w_cond = (w_a >  0);
      BK_BLTZ: w_cond = (w_a <  0);
      BK_BGEZ: w_cond = (w_a >= 0);
      default: w_cond = 1'b0;
    endcase
  end

  // Load-use hazard: the load's data only exists once it reaches MEM.
  // r0 is excluded since its value is constant and never forwarded.
  logic w_hazard;
  assign w_hazard = w_is_br && EX_MemRead && (EX_WriteReg != 5'd0) &&
                    ((EX_WriteReg == w_rs) ||
                     (w_dec.use_rt && (EX_WriteReg == w_rt)));

  // ---------------- FSM ----------------
  brs_state_t r_state, w_state_nxt;
  logic       w_stall, w_resolve;

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // STALL re-evaluates the same held instruction; by then the load sits in
  // MEM and is forwarded. A fresh hazard (another load) keeps us in STALL.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_resolve   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_hazard) begin
          w_stall     = 1'b1;
          w_state_nxt = ST_STALL;
        end else begin
          w_resolve   = w_is_br;
        end
      end
      ST_STALL: begin
        if (w_hazard) begin
          w_stall     = 1'b1;
        end else begin
          w_resolve   = w_is_br;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  logic w_taken;
  assign w_taken = w_resolve && w_cond;

  // ---------------- registered outputs ----------------
  logic             r_branch, r_link, r_stall;
  logic [OFF_W-1:0] r_jamt;
  logic [CNT_W-1:0] r_bcnt, r_tcnt;

  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_branch <= 1'b0;
      r_jamt   <= '0;
      r_link   <= 1'b0;
      r_stall  <= 1'b0;
    end else begin
      r_branch <= w_taken;
      r_jamt   <= w_taken ? w_off : '0;
      r_link   <= w_resolve && w_dec.link;
      r_stall  <= w_stall;
    end
  end

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_bcnt <= '0;
      r_tcnt <= '0;
    end else if (w_resolve) begin
      if (r_bcnt != '1)           r_bcnt <= r_bcnt + CNT_W'(1);
      if (w_taken && r_tcnt != '1) r_tcnt <= r_tcnt + CNT_W'(1);
    end
  end

  assign Branch      = r_branch;
  assign JumpAmount  = r_jamt;
  assign Link        = r_link;
  assign Stall       = r_stall;
  assign BranchCount = r_bcnt;
  assign TakenCount  = r_tcnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//   Two instances share stimulus: default widths, and CNT_W=2 for the
//   saturation behaviour. Each step's expected outputs come from a small
//   behavioural model, are queued when driven and compared after the
//   falling edge on which the DUT updates.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = '0;
  logic        valid = 1'b0;
  logic [31:0] rd1 = '0, rd2 = '0;
  logic        ex_rw = 0, ex_mr = 0;
  logic [4:0]  ex_wr = '0;
  logic [31:0] ex_res = '0;
  logic        mem_rw = 0, mem_mr = 0;
  logic [4:0]  mem_wr = '0;
  logic [31:0] mem_alu = '0, mem_dm = '0;
  logic        wb_rw = 0;
  logic [4:0]  wb_wr = '0;
  logic [31:0] wb_res = '0;

  logic        br, lnk, stl, br2, lnk2, stl2;
  logic [15:0] ja, ja2;
  logic [15:0] bc, tc;
  logic [1:0]  bc2, tc2;

  always #5 clk = ~clk;

  branch_resolve_unit #(.DATA_W(32), .OFF_W(16), .CNT_W(16), .LINK_EN(1)) dut (
    .Clk(clk), .Rst_n(rst_n), .ID_Instr(instr), .ID_Valid(valid),
    .ID_ReadData1(rd1), .ID_ReadData2(rd2),
    .EX_RegWrite(ex_rw), .EX_MemRead(ex_mr), .EX_WriteReg(ex_wr), .EX_Result(ex_res),
    .MEM_RegWrite(mem_rw), .MEM_MemRead(mem_mr), .MEM_WriteReg(mem_wr),
    .MEM_AluOut(mem_alu), .MEM_DataMemOut(mem_dm),
    .WB_RegWrite(wb_rw), .WB_WriteReg(wb_wr), .WB_Result(wb_res),
    .Branch(br), .JumpAmount(ja), .Link(lnk), .Stall(stl),
    .BranchCount(bc), .TakenCount(tc));

  branch_resolve_unit #(.DATA_W(32), .OFF_W(16), .CNT_W(2), .LINK_EN(1)) dut2 (
    .Clk(clk), .Rst_n(rst_n), .ID_Instr(instr), .ID_Valid(valid),
    .ID_ReadData1(rd1), .ID_ReadData2(rd2),
    .EX_RegWrite(ex_rw), .EX_MemRead(ex_mr), .EX_WriteReg(ex_wr), .EX_Result(ex_res),
    .MEM_RegWrite(mem_rw), .MEM_MemRead(mem_mr), .MEM_WriteReg(mem_wr),
    .MEM_AluOut(mem_alu), .MEM_DataMemOut(mem_dm),
    .WB_RegWrite(wb_rw), .WB_WriteReg(wb_wr), .WB_Result(wb_res),
    .Branch(br2), .JumpAmount(ja2), .Link(lnk2), .Stall(stl2),
    .BranchCount(bc2), .TakenCount(tc2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h @%0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        br;
    logic [15:0] ja;
    logic        lnk;
    logic        stl;
    int          bc;
    int          tc;
  } exp_t;

  exp_t sb[$];
  int   m_bc = 0, m_tc = 0;

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] off);
    return {op, rs, rt, off};
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0)                       return rf;
    if (ex_rw  && ex_wr  == idx)        return ex_res;
    if (mem_rw && mem_wr == idx)        return mem_mr ? mem_dm : mem_alu;
    if (wb_rw  && wb_wr  == idx)        return wb_res;
    return rf;
  endfunction

  // Behavioural reference: expected outputs for the inputs currently driven.
  task automatic model_push();
    exp_t e;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic signed [31:0] a, b;
    logic isbr, use_rt, cond, l, haz;
    op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16];
    a = fwd(rs, rd1); b = fwd(rt, rd2);
    isbr = 0; use_rt = 0; cond = 0; l = 0;
    case (op)
      6'h04: begin isbr = 1; use_rt = 1; cond = (a == b); end
      6'h05: begin isbr = 1; use_rt = 1; cond = (a != b); end
      6'h06: if (rt == 0) begin isbr = 1; cond = (a <= 0); end
      6'h07: if (rt == 0) begin isbr = 1; cond = (a > 0); end
      6'h01: begin
        if (rt == 5'd0)  begin isbr = 1; cond = (a < 0); end
        if (rt == 5'd1)  begin isbr = 1; cond = (a >= 0); end
        if (rt == 5'd16) begin isbr = 1; cond = (a < 0); l = 1; end
        if (rt == 5'd17) begin isbr = 1; cond = (a >= 0); l = 1; end
      end
      default: ;
    endcase
    isbr = isbr && valid;
    haz  = isbr && ex_mr && (ex_wr != 0) && (ex_wr == rs || (use_rt && ex_wr == rt));
    e.br = 0; e.ja = 0; e.lnk = 0; e.stl = 0;
    if (haz) e.stl = 1;
    else if (isbr) begin
      e.br = cond; e.ja = cond ? instr[15:0] : 16'h0; e.lnk = l;
      m_bc++; if (cond) m_tc++;
    end
    e.bc = m_bc; e.tc = m_tc;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic step(input string tag);
    exp_t e;
    model_push();
    @(negedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".br"},  br,  e.br);
    chk({tag, ".ja"},  ja,  e.ja);
    chk({tag, ".lnk"}, lnk, e.lnk);
    chk({tag, ".stl"}, stl, e.stl);
    chk({tag, ".bc"},  bc,  sat(e.bc, 65535));
    chk({tag, ".tc"},  tc,  sat(e.tc, 65535));
    chk({tag, ".bc2"}, bc2, sat(e.bc, 3));
    chk({tag, ".tc2"}, tc2, sat(e.tc, 3));
  endtask

  task automatic clr_fwd();
    ex_rw = 0; ex_mr = 0; ex_wr = 0; ex_res = 0;
    mem_rw = 0; mem_mr = 0; mem_wr = 0; mem_alu = 0; mem_dm = 0;
    wb_rw = 0; wb_wr = 0; wb_res = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1 rst_n = 0;
    #2;
    chk("rst.br", br, 0); chk("rst.ja", ja, 0); chk("rst.lnk", lnk, 0);
    chk("rst.stl", stl, 0); chk("rst.bc", bc, 0); chk("rst.tc", tc, 0);
    @(negedge clk); #1;
    rst_n = 1;

    // beq r1,r2 equal from the register file; first edge after reset
    valid = 1; rd1 = 5; rd2 = 5; instr = enc(6'h04, 1, 2, 16'h0010);
    step("beq_rf");
    chk("beq_rf.lit_br", br, 1); chk("beq_rf.lit_ja", ja, 16'h0010);
    chk("beq_rf.lit_bc", bc, 1); chk("beq_rf.lit_tc", tc, 1);

    // bne r3,r4: EX beats MEM beats regfile
    rd1 = 7; rd2 = 7; ex_rw = 1; ex_wr = 3; ex_res = 9;
    mem_rw = 1; mem_wr = 3; mem_alu = 4;
    instr = enc(6'h05, 3, 4, 16'h0020);
    step("bne_ex");
    chk("bne_ex.lit_br", br, 1);
    // beq variant: taken only if EX (=7) is chosen over MEM (=4)
    ex_res = 7; instr = enc(6'h04, 3, 4, 16'h0030);
    step("beq_expri");
    chk("beq_expri.lit_br", br, 1);
    // MEM over WB, MEM load data selected when MemRead
    clr_fwd(); mem_rw = 1; mem_mr = 1; mem_wr = 3; mem_alu = 7; mem_dm = 2;
    wb_rw = 1; wb_wr = 3; wb_res = 7;
    step("beq_memdm");
    chk("beq_memdm.lit_br", br, 0);
    clr_fwd(); wb_rw = 1; wb_wr = 4; wb_res = 7; rd2 = 1;
    step("beq_wb");

    // load-use: lw r5 in EX, bgtz r5 -> one stall, then resolve from MEM
    clr_fwd(); rd1 = 0; ex_rw = 1; ex_mr = 1; ex_wr = 5;
    instr = enc(6'h07, 5, 0, 16'h0044);
    step("lu_stall");
    chk("lu_stall.lit_stl", stl, 1); chk("lu_stall.lit_br", br, 0);
    clr_fwd(); mem_rw = 1; mem_mr = 1; mem_wr = 5; mem_dm = 1;
    step("lu_resolve");
    chk("lu_resolve.lit_br", br, 1); chk("lu_resolve.lit_stl", stl, 0);

    // repeated hazard keeps stalling
    clr_fwd(); ex_rw = 1; ex_mr = 1; ex_wr = 5;
    step("rep_stall0");
    step("rep_stall1");
    chk("rep_stall1.lit_stl", stl, 1);
    clr_fwd();
    step("rep_resolve");

    // unused rt does not stall: bgez r8 (rt field 1) with load to r1 in EX
    ex_rw = 1; ex_mr = 1; ex_wr = 1; rd1 = 3;
    instr = enc(6'h01, 8, 1, 16'h0050);
    step("unused_rt");
    chk("unused_rt.lit_stl", stl, 0);
    clr_fwd();

    // linking branches
    rd1 = 32'hFFFF_FFFF;
    instr = enc(6'h01, 6, 5'd16, 16'h0060);
    step("bltzal");
    chk("bltzal.lit_lnk", lnk, 1); chk("bltzal.lit_br", br, 1);
    instr = enc(6'h01, 6, 5'd17, 16'h0070);
    step("bgezal");
    chk("bgezal.lit_lnk", lnk, 1); chk("bgezal.lit_br", br, 0);

    // bubble and non-branch
    valid = 0; instr = enc(6'h04, 0, 0, 16'h0080);
    step("bubble");
    valid = 1; instr = enc(6'h08, 1, 2, 16'h0090);
    step("nonbr");
    instr = enc(6'h06, 1, 2, 16'h0090);   // blez with rt!=0 is not a branch
    step("blez_badrt");

    // r0 is never forwarded
    ex_rw = 1; ex_wr = 0; ex_res = 32'hFFFF_FFFF; rd1 = 0;
    instr = enc(6'h06, 0, 0, 16'h00A0);
    step("blez_r0");
    chk("blez_r0.lit_br", br, 1);
    clr_fwd();

    // saturation of the 2-bit counters
    rd1 = 0; rd2 = 0;
    for (int i = 0; i < 5; i++) begin
      instr = enc(6'h04, 0, 0, 16'h0100 + 16'(i));
      step("sat");
    end
    chk("sat.lit_bc2", bc2, 3); chk("sat.lit_tc2", tc2, 3);

    // random mix
    for (int i = 0; i < 150; i++) begin
      logic [5:0] op;
      logic [4:0] rt;
      int sel;
      sel = $urandom_range(0, 6);
      op = (sel == 0) ? 6'h04 : (sel == 1) ? 6'h05 : (sel == 2) ? 6'h06 :
           (sel == 3) ? 6'h07 : (sel == 4) ? 6'h09 : 6'h01;
      rt = 5'($urandom_range(0, 3));
      if (op == 6'h01) begin
        case ($urandom_range(0, 4))
          0: rt = 5'd0; 1: rt = 5'd1; 2: rt = 5'd16; 3: rt = 5'd17; default: rt = 5'd2;
        endcase
      end else if ((op == 6'h06 || op == 6'h07) && $urandom_range(0, 3) != 0) rt = 0;
      instr  = enc(op, 5'($urandom_range(0, 3)), rt, 16'($urandom));
      valid  = ($urandom_range(0, 9) != 0);
      rd1    = $urandom_range(0, 6) - 3;
      rd2    = $urandom_range(0, 6) - 3;
      ex_rw  = 1'($urandom); ex_mr = ($urandom_range(0, 4) == 0);
      ex_wr  = 5'($urandom_range(0, 3)); ex_res = $urandom_range(0, 6) - 3;
      mem_rw = 1'($urandom); mem_mr = 1'($urandom);
      mem_wr = 5'($urandom_range(0, 3));
      mem_alu = $urandom_range(0, 6) - 3; mem_dm = $urandom_range(0, 6) - 3;
      wb_rw  = 1'($urandom); wb_wr = 5'($urandom_range(0, 3));
      wb_res = $urandom_range(0, 6) - 3;
      step("rnd");
    end

    // async reset while stalled
    clr_fwd(); valid = 1; rd1 = 0;
    ex_rw = 1; ex_mr = 1; ex_wr = 5;
    instr = enc(6'h07, 5, 0, 16'h0044);
    step("pre_rst_stall");
    chk("pre_rst_stall.lit_stl", stl, 1);
    #2 rst_n = 0;
    #1;
    chk("midrst.stl", stl, 0); chk("midrst.bc", bc, 0); chk("midrst.tc", tc, 0);
    chk("midrst.br", br, 0); chk("midrst.bc2", bc2, 0);
    m_bc = 0; m_tc = 0;
    @(negedge clk); #1;
    rst_n = 1;
    clr_fwd(); rd1 = 4; rd2 = 4;
    instr = enc(6'h04, 1, 2, 16'h0123);
    step("post_rst");
    chk("post_rst.lit_bc", bc, 1); chk("post_rst.lit_ja", ja, 16'h0123);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
